// File: rtl/divider8x4.sv
// divider8x4: sequential restoring divider, DW-bit unsigned dividend by
// VW-bit unsigned divisor. One quotient bit is resolved per clock. A zero
// divisor skips the iterations and reports all-ones with divide_by_zero set.
// The start/done handshake matches the shift-add multiplier so that a single
// controller can drive both blocks.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for process_start; operands are captured on accept
// CALC  | one shift / trial-subtract iteration per clock, DW in total
// ZERO  | divisor was 0; load the all-ones result and set the flag
// DONE  | result valid; process_done is high for this one cycle

module divider8x4 #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          CLK,
    input  logic          RESETn,
    input  logic          process_start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          process_done,
    output logic          divide_by_zero
);

    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        ZERO = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    state_t        next_state;

    logic [DW-1:0] shreg;
    logic [VW-1:0] dvsr;
    logic [VW:0]   prem;
    logic [CW-1:0] cnt;

    logic [VW:0]   trial;
    logic [VW:0]   diff;
    logic          fits;
    logic [VW:0]   prem_nxt;
    logic [DW-1:0] shreg_nxt;
    logic          last_iter;

    // State register; a low RESETn at the edge returns to IDLE from anywhere.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; start is only looked at while IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (process_start) begin
                    next_state = (divisor == '0) ? ZERO : CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    next_state = DONE;
                end
            end
            ZERO:    next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // One restoring iteration: shift {prem, shreg} left, trial-subtract the
    // divisor, keep the difference and shift in 1 if it did not go negative.
    // prem[VW] stays 0 because prem < divisor after every step; it still takes
    // part in the compare so the trial is correct on the full register.
    always_comb begin
        trial     = {prem[VW-1:0], shreg[DW-1]};
        fits      = prem[VW] | (trial >= {1'b0, dvsr});
        diff      = trial - {1'b0, dvsr};
        prem_nxt  = fits ? diff : trial;
        shreg_nxt = {shreg[DW-2:0], fits};
        last_iter = (cnt == CW'(DW - 1));
    end

    // Datapath and registered outputs; results only change on the result edge.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            shreg          <= '0;
            dvsr           <= '0;
            prem           <= '0;
            cnt            <= '0;
            quotient       <= '0;
            remainder      <= '0;
            process_done   <= 1'b0;
            divide_by_zero <= 1'b0;
        end else begin
            process_done <= (next_state == DONE);
            case (state)
                IDLE: begin
                    if (process_start && (divisor != '0)) begin
                        shreg          <= dividend;
                        dvsr           <= divisor;
                        prem           <= '0;
                        cnt            <= '0;
                        divide_by_zero <= 1'b0;
                    end
                end
                CALC: begin
                    shreg <= shreg_nxt;
                    prem  <= prem_nxt;
                    cnt   <= cnt + 1'b1;
                    if (last_iter) begin
                        quotient  <= shreg_nxt;
                        remainder <= prem_nxt[VW-1:0];
                    end
                end
                ZERO: begin
                    quotient       <= '1;
                    remainder      <= '1;
                    divide_by_zero <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider8x4.sv
// Self-checking bench for divider8x4: directed cases from the block's
// description plus randomized operands against plain integer division.

module tb_divider8x4;

    logic       CLK;
    logic       RESETn;
    logic       process_start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       process_done;
    logic       divide_by_zero;

    int n_vec;
    int n_bad;
    int cyc;

    divider8x4 dut (
        .CLK            (CLK),
        .RESETn         (RESETn),
        .process_start  (process_start),
        .dividend       (dividend),
        .divisor        (divisor),
        .quotient       (quotient),
        .remainder      (remainder),
        .process_done   (process_done),
        .divide_by_zero (divide_by_zero)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input int observed, input int expected);
        n_vec++;
        if (observed !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     tag, observed, observed, expected, expected);
        end
    endtask

    // Launch one division from IDLE, scramble the inputs after the accept
    // edge, then check latency, result, flag and that done is a single pulse.
    task automatic do_div(input logic [7:0] a, input logic [3:0] b);
        int exp_q, exp_r, exp_z, exp_lat, lat;
        if (b == 4'd0) begin
            exp_q = 8'hFF; exp_r = 4'hF; exp_z = 1; exp_lat = 2;
        end else begin
            exp_q = int'(a) / int'(b);
            exp_r = int'(a) % int'(b);
            exp_z = 0; exp_lat = 9;
        end
        @(negedge CLK);
        dividend      = a;
        divisor       = b;
        process_start = 1'b1;
        @(posedge CLK);
        #1;
        process_start = 1'b0;
        dividend      = 8'($urandom);
        divisor       = 4'($urandom);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge CLK);
            if (process_done) begin
                lat = n;
                break;
            end
        end
        chk("latency", lat, exp_lat);
        chk("quotient", int'(quotient), exp_q);
        chk("remainder", int'(remainder), exp_r);
        chk("div_by_zero", int'(divide_by_zero), exp_z);
        if (b != 4'd0) begin
            chk("identity", int'(quotient) * int'(b) + int'(remainder), int'(a));
            chk("rem_lt_div", int'(remainder < b), 1);
        end
        @(negedge CLK);
        chk("done_single", int'(process_done), 0);
    endtask

    initial begin
        int pulses, t0, t1;
        logic [7:0] ra;
        logic [3:0] rb;

        n_vec = 0;
        n_bad = 0;
        cyc   = 0;
        RESETn        = 1'b0;
        process_start = 1'b0;
        dividend      = 8'h00;
        divisor       = 4'h0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_done", int'(process_done), 0);
        chk("rst_dbz", int'(divide_by_zero), 0);
        RESETn = 1'b1;

        do_div(8'h24, 4'h9);
        do_div(8'h64, 4'h7);
        do_div(8'h05, 4'hF);
        do_div(8'hFF, 4'h1);
        do_div(8'h3C, 4'h0);
        do_div(8'h24, 4'h9);

        // start pulsed mid-operation with new operands must be ignored
        @(negedge CLK);
        dividend = 8'd100; divisor = 4'd7; process_start = 1'b1;
        @(posedge CLK);
        #1 process_start = 1'b0;
        repeat (3) @(negedge CLK);
        dividend = 8'h24; divisor = 4'h9; process_start = 1'b1;
        @(negedge CLK);
        process_start = 1'b0; dividend = 8'hAA; divisor = 4'h0;
        pulses = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge CLK);
            if (process_done) pulses++;
        end
        chk("ignored_pulses", pulses, 1);
        chk("ignored_q", int'(quotient), 14);
        chk("ignored_r", int'(remainder), 2);

        // synchronous reset mid-operation abandons the division
        @(negedge CLK);
        dividend = 8'd200; divisor = 4'd3; process_start = 1'b1;
        @(posedge CLK);
        #1 process_start = 1'b0;
        repeat (4) @(negedge CLK);
        RESETn = 1'b0;
        @(negedge CLK);
        RESETn = 1'b1;
        chk("midrst_q", int'(quotient), 0);
        chk("midrst_r", int'(remainder), 0);
        chk("midrst_dbz", int'(divide_by_zero), 0);
        pulses = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge CLK);
            if (process_done) pulses++;
        end
        chk("midrst_no_done", pulses, 0);
        do_div(8'd200, 4'd3);

        // start held high: back-to-back divisions ten cycles apart
        @(negedge CLK);
        dividend = 8'h24; divisor = 4'h9; process_start = 1'b1;
        pulses = 0; t0 = -1; t1 = -1;
        for (int n = 0; n < 24; n++) begin
            @(negedge CLK);
            if (process_done) begin
                if (pulses == 0) t0 = cyc;
                else if (pulses == 1) t1 = cyc;
                pulses++;
            end
        end
        process_start = 1'b0;
        chk("b2b_pulses", pulses, 2);
        chk("b2b_spacing", t1 - t0, 10);
        chk("b2b_q", int'(quotient), 4);
        repeat (12) @(negedge CLK);

        // randomized operands, roughly one in sixteen with a zero divisor
        for (int k = 0; k < 150; k++) begin
            ra = 8'($urandom);
            rb = 4'($urandom);
            do_div(ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/divider8x4.md
Name: divider8x4

Overview:
- Sequential restoring divider: 8-bit unsigned dividend by 4-bit unsigned divisor, giving an 8-bit quotient and a 4-bit remainder.
- It is the inverse of the FSM shift-add 4x4 multiplier and uses the same start/done handshake, so the two can sit side by side behind one controller.
- The divider produces one quotient bit per clock and flags division by zero.

Parameters:
- DW, 8, dividend and quotient width; this is also the number of iterations.
- VW, 4, divisor and remainder width.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESETn  input  1  synchronous, active-low reset, sampled on the rising edge of CLK.
- process_start  input  1  start request; sampled only in IDLE.
- dividend  input  DW  unsigned dividend; captured on the accept edge.
- divisor  input  VW  unsigned divisor; captured on the accept edge.
- quotient  output  DW  registered quotient; holds until the next accept.
- remainder  output  VW  registered remainder; holds until the next accept.
- process_done  output  1  registered, one-cycle pulse when the result is valid.
- divide_by_zero  output  1  registered flag; set when the captured divisor was 0.

Behaviour:
- Reset: RESETn low at a rising edge forces the following.
  - state goes to IDLE.
  - quotient, remainder, process_done, divide_by_zero and all internal registers go to 0.
  - Reset takes effect mid-operation too: the current division is abandoned and no process_done is issued.
- States and transitions:
  - IDLE: process_start=1 at edge E0 accepts the request.
    - divisor!=0: latch dividend into the shift register and divisor into the divisor register, clear the (VW+1)-bit partial remainder and the iteration counter, clear divide_by_zero, then go to CALC.
    - divisor==0: go to ZERO.
    - process_start=0: stay in IDLE.
  - CALC: each edge performs one iteration.
    - Shift {partial remainder, dividend shift register} left by 1.
    - Trial-subtract the divisor from the partial remainder.
    - Result non-negative: keep the difference and shift in quotient bit 1.
    - Otherwise: restore the partial remainder and shift in quotient bit 0.
    - The counter increments each edge. After iteration DW (edge E8), move to DONE and load quotient and remainder (low VW bits of the partial remainder) into the output registers.
  - ZERO: at the next edge (E1), set quotient to all-ones (8'hFF), set remainder to all-ones (4'hF), set divide_by_zero=1, then go to DONE.
  - DONE: process_done=1 for exactly this one cycle; the next edge goes unconditionally to IDLE.
- Latency:
  - Normal division: process_done is high in the cycle after E8, i.e. 9 cycles after the accept edge.
  - Divide by zero: process_done is high in the cycle after E1.
- Handshake:
  - process_start is ignored in CALC, ZERO and DONE; no queuing, no restart.
  - The earliest new accept is the edge that ends DONE+1, i.e. start sampled while in IDLE again.
  - A start held high continuously launches back-to-back divisions separated by one IDLE cycle.
  - Changes to dividend or divisor after the accept edge do not affect the running operation.
- Outputs:
  - quotient and remainder change only at the result edge; they are not cleared at accept.
  - divide_by_zero is cleared at the next accept and holds otherwise.
- Arithmetic:
  - The partial remainder is VW+1 bits, so no overflow is possible; the invariant is remainder < divisor.
  - Quotient fits in DW bits for all nonzero divisors, and dividend == quotient*divisor + remainder.

Test Plan:
- After reset, start with dividend=8'h24 (36), divisor=4'h9 -> process_done pulses 9 cycles after accept with quotient=8'h04, remainder=4'h0, divide_by_zero=0.
- dividend=8'h64 (100), divisor=4'h7 -> quotient=8'h0E, remainder=4'h2. dividend=8'h05, divisor=4'hF -> quotient=8'h00, remainder=4'h5. dividend=8'hFF, divisor=4'h1 -> quotient=8'hFF, remainder=4'h0.
- divisor=0, dividend=8'h3C -> process_done in the cycle after E1, quotient=8'hFF, remainder=4'hF, divide_by_zero=1. A following 36/9 request clears divide_by_zero.
- Start 100/7, then pulse process_start with 8'h24/4'h9 at cycle 4 and change the inputs -> the request is ignored and the result is still 14 r2 with a single process_done pulse.
- Start 200/3, assert RESETn=0 at cycle 5 for one edge -> all outputs are 0 and there is no process_done. A restarted 200/3 yields quotient=8'h42, remainder=4'h2.
- Hold process_start=1 across two operations -> two process_done pulses separated by 10 cycles. Exhaustive random check against dividend == q*d + r with r < d.
